dso_capture_ctrl: RTL and testbench

//  Sample-capture controller for the DSO datapath; consumes the 1-bit write-enable level driven
//  by the NIOS2 wren PIO. Rising edge of wren arms a capture: block waits for a level-crossing

---
 rtl/dso_cap_pkg.sv | 15 +
 rtl/dso_trig_detect.sv | 44 ++++
 rtl/dso_capture_ctrl.sv | 170 +++++++++++++++++
 tb/tb_dso_capture_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dso_cap_pkg.sv
// Shared state encoding and trigger-edge constants for the DSO sample-capture controller.
package dso_cap_pkg;

    typedef enum logic [2:0] {
        CAP_IDLE,
        CAP_PREFILL,
        CAP_WAIT_TRIG,
        CAP_POST,
        CAP_DONE
    } cap_state_t;

    localparam logic TRIG_RISE = 1'b0;
    localparam logic TRIG_FALL = 1'b1;

endpackage

// File: rtl/dso_trig_detect.sv
// Level-crossing trigger detector: remembers the previous valid sample and flags a crossing
// (or a forced trigger) combinationally on the cycle the new sample is valid.
module dso_trig_detect
    import dso_cap_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic              trig_force,
    input  logic              clear,
    output logic              trig
);

    logic [DATA_W-1:0] prev;
    logic              prev_valid;
    logic              rise_cross;
    logic              fall_cross;

    // A clear (capture arm) wins over a coincident sample so the first post-arm sample has no history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (clear) begin
            prev_valid <= 1'b0;
        end else if (adc_valid) begin
            prev       <= adc_data;
            prev_valid <= 1'b1;
        end
    end

    assign rise_cross = (prev < trig_level) && (adc_data >= trig_level);
    assign fall_cross = (prev > trig_level) && (adc_data <= trig_level);

    assign trig = adc_valid &&
                  (trig_force || (prev_valid && ((trig_edge == TRIG_FALL) ? fall_cross : rise_cross)));

endmodule

// File: rtl/dso_capture_ctrl.sv
// DSO sample-capture controller: arms on wren rising, waits for a trigger, writes DEPTH samples.
// Optional pre-trigger ring buffer enabled by defining DSO_CAP_PRETRIG_EN.
module dso_capture_ctrl
    import dso_cap_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 10,
    parameter int PRE_N  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wren,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic              trig_force,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr
);

    localparam int DEPTH = 1 << ADDR_W;
`ifdef DSO_CAP_PRETRIG_EN
    localparam bit              PRETRIG = 1'b1;
    localparam logic [ADDR_W:0] PRE_CNT = (ADDR_W+1)'(PRE_N);
`else
    localparam bit              PRETRIG = 1'b0;
`endif
    localparam logic [ADDR_W:0] POST_CNT = (ADDR_W+1)'(PRETRIG ? DEPTH - PRE_N : DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

    cap_state_t        state;
    cap_state_t        state_nx;
    logic              wren_d;
    logic              arm;
    logic              trig;
    logic              start;
    logic              wr;
    logic              trig_hit;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_nx;
    logic [ADDR_W:0]   count_inc;
    logic [ADDR_W-1:0] wptr;

    assign arm       = wren && !wren_d;
    assign count_inc = count + 1'b1;

    dso_trig_detect #(.DATA_W(DATA_W)) u_trig (
        .clk        (clk),
        .reset_n    (reset_n),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .trig_force (trig_force),
        .clear      (start),
        .trig       (trig)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CAP_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Dropping wren in any active state aborts; no new write is started on that cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx = state;
        count_nx = count;
        start    = 1'b0;
        wr       = 1'b0;
        trig_hit = 1'b0;
        case (state)
            CAP_IDLE: begin
                if (arm) begin
                    start    = 1'b1;
                    count_nx = '0;
`ifdef DSO_CAP_PRETRIG_EN
                    state_nx = CAP_PREFILL;
`else
                    state_nx = CAP_WAIT_TRIG;
`endif
                end
            end
`ifdef DSO_CAP_PRETRIG_EN
            CAP_PREFILL: begin
                if (!wren) begin
                    state_nx = CAP_IDLE;
                end else if (adc_valid) begin
                    wr       = 1'b1;
                    count_nx = count_inc;
                    if (count_inc == PRE_CNT) begin
                        state_nx = CAP_WAIT_TRIG;
                    end
                end
            end
`endif
            CAP_WAIT_TRIG: begin
                if (!wren) begin
                    state_nx = CAP_IDLE;
                end else if (trig) begin
                    wr       = 1'b1;
                    trig_hit = 1'b1;
                    count_nx = ONE_CNT;
                    state_nx = (POST_CNT == ONE_CNT) ? CAP_DONE : CAP_POST;
`ifdef DSO_CAP_PRETRIG_EN
                end else if (adc_valid) begin
                    wr = 1'b1;
`endif
                end
            end
            CAP_POST: begin
                if (!wren) begin
                    state_nx = CAP_IDLE;
                end else if (adc_valid) begin
                    wr       = 1'b1;
                    count_nx = count_inc;
                    if (count_inc == POST_CNT) begin
                        state_nx = CAP_DONE;
                    end
                end
            end
            CAP_DONE: begin
                if (!wren) begin
                    state_nx = CAP_IDLE;
                end
            end
            default: state_nx = CAP_IDLE;
        endcase
    end

    // Registered write port: each accepted sample appears on the RAM port exactly one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wren_d    <= 1'b0;
            count     <= '0;
            wptr      <= '0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            trig_addr <= '0;
        end else begin
            wren_d <= wren;
            count  <= count_nx;
            ram_we <= wr;
            if (start) begin
                wptr      <= '0;
                ram_waddr <= '0;
            end else if (wr) begin
                wptr      <= wptr + 1'b1;
                ram_waddr <= wptr;
                ram_wdata <= adc_data;
            end
            if (trig_hit) begin
                trig_addr <= wptr;
            end
        end
    end

    assign busy = (state != CAP_IDLE) && (state != CAP_DONE);
    assign done = (state == CAP_DONE);

endmodule

// File: tb/tb_dso_capture_ctrl.sv
// Self-checking bench for dso_capture_ctrl: sample streams are scored against a model that derives
// the trigger index and the capture window directly from the trigger and buffering rules.
module tb_dso_capture_ctrl;
    import dso_cap_pkg::*;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PRE_N  = 256;
`ifdef DSO_CAP_PRETRIG_EN
    localparam int PRE = PRE_N;
`else
    localparam int PRE = 0;
`endif
    localparam int POST_N = DEPTH - PRE;
    localparam int NO_END = 32'h7fff_ffff;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wren;
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic [DATA_W-1:0] trig_level;
    logic              trig_edge;
    logic              trig_force;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] trig_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int stim[$];
    logic [DATA_W-1:0] tb_ram [DEPTH];

    dso_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PRE_N(PRE_N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wren       (wren),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .trig_force (trig_force),
        .ram_we     (ram_we),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .busy       (busy),
        .done       (done),
        .trig_addr  (trig_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) tb_ram[ram_waddr] <= ram_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit crosses(int p, int s, logic edge_sel, int lvl);
        if (edge_sel == TRIG_RISE) return (p < lvl) && (s >= lvl);
        return (p > lvl) && (s <= lvl);
    endfunction

    // Index of the triggering sample, or -1; trigger is only eligible once the pre-trigger fill is done.
    function automatic int find_trig(logic edge_sel, int lvl, logic force_sel);
        for (int i = PRE; i < stim.size(); i++) begin
            if (force_sel || (i >= 1 && crosses(stim[i-1], stim[i], edge_sel, lvl))) return i;
        end
        return -1;
    endfunction

    task automatic run_capture(input string name, input logic edge_sel, input int lvl, input logic force_sel,
                               input int gap_lo, input int gap_hi, input int abort_at);
        int  k, w_end, w_start, base, bad, gap, idx;
        bit  exp_we, finished, aborted;
        k        = find_trig(edge_sel, lvl, force_sel);
        base     = (PRE > 0) ? 0 : k;
        w_start  = (PRE > 0) ? 0 : ((k < 0) ? NO_END : k);
        w_end    = (k < 0) ? NO_END : k + POST_N - 1;
        finished = 1'b0;
        aborted  = 1'b0;
        trig_edge  = edge_sel;
        trig_level = DATA_W'(lvl);
        trig_force = force_sel;
        adc_valid  = 1'b0;
        wren       = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s armed_busy: got %b want 1", name, busy); end
        for (int i = 0; i < stim.size(); i++) begin
            gap = $urandom_range(gap_hi, gap_lo);
            for (int g = 0; g < gap; g++) begin
                step();
                n_checks++;
                if (ram_we !== 1'b0) begin n_fail++; $display("FAIL %s idle_write: got %b want 0 before sample %0d", name, ram_we, i); end
            end
            adc_data  = DATA_W'(stim[i]);
            adc_valid = 1'b1;
            step();
            adc_valid = 1'b0;
            exp_we = (i >= w_start) && (i <= w_end);
            n_checks++;
            if (ram_we !== exp_we) begin n_fail++; $display("FAIL %s we: sample %0d got %b want %b", name, i, ram_we, exp_we); end
            if (exp_we) begin
                n_checks++;
                if (ram_waddr !== ADDR_W'((i - base) % DEPTH)) begin
                    n_fail++; $display("FAIL %s waddr: sample %0d got %0d want %0d", name, i, ram_waddr, (i - base) % DEPTH);
                end
                n_checks++;
                if (ram_wdata !== DATA_W'(stim[i])) begin
                    n_fail++; $display("FAIL %s wdata: sample %0d got %0d want %0d", name, i, ram_wdata, stim[i]);
                end
            end
            n_checks++;
            if (done !== (i == w_end)) begin n_fail++; $display("FAIL %s done: sample %0d got %b want %b", name, i, done, i == w_end); end
            if (i == w_end) begin finished = 1'b1; break; end
            if (i == abort_at) begin aborted = 1'b1; break; end
        end
        if (finished) begin
            adc_data  = DATA_W'($urandom_range(DEPTH-1, 0));
            adc_valid = 1'b1;
            step();
            adc_valid = 1'b0;
            n_checks++;
            if (ram_we !== 1'b0 || done !== 1'b1) begin
                n_fail++; $display("FAIL %s done_hold: got we=%b done=%b want we=0 done=1", name, ram_we, done);
            end
            n_checks++;
            if (trig_addr !== ADDR_W'((k - base) % DEPTH)) begin
                n_fail++; $display("FAIL %s trig_addr: got %0d want %0d", name, trig_addr, (k - base) % DEPTH);
            end
            n_checks++;
            if (tb_ram[trig_addr] !== DATA_W'(stim[k])) begin
                n_fail++; $display("FAIL %s trig_sample: got %0d want %0d", name, tb_ram[trig_addr], stim[k]);
            end
            bad = 0;
            for (int j = 0; j < DEPTH; j++) begin
                idx = w_end - j;
                if (tb_ram[(idx - base) % DEPTH] !== DATA_W'(stim[idx])) bad++;
            end
            n_checks++;
            if (bad != 0) begin n_fail++; $display("FAIL %s ram_image: got %0d wrong words want 0", name, bad); end
            wren = 1'b0;
            step();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL %s release: got done=%b busy=%b want 0 0", name, done, busy);
            end
        end else if (aborted) begin
            wren = 1'b0;
            step();
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0) begin
                n_fail++; $display("FAIL %s abort: got busy=%b done=%b we=%b want 0 0 0", name, busy, done, ram_we);
            end
            n_checks++;
            if (k >= 0 && trig_addr !== ADDR_W'((k - base) % DEPTH)) begin
                n_fail++; $display("FAIL %s abort_trig_addr: got %0d want %0d", name, trig_addr, (k - base) % DEPTH);
            end
        end else begin
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL %s no_done: got done=%b busy=%b want 0 1", name, done, busy);
            end
            wren = 1'b0;
            step();
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL %s idle_after_drop: got busy=%b want 0", name, busy); end
        end
        step();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({ram_we, ram_waddr, ram_wdata, busy, done, trig_addr} !== '0) begin
            n_fail++; $display("FAIL reset_values: got we=%b waddr=%0d wdata=%0d busy=%b done=%b taddr=%0d want all 0",
                               ram_we, ram_waddr, ram_wdata, busy, done, trig_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got busy=%b done=%b we=%b want 0 0 0", busy, done, ram_we);
        end
    endtask

    task automatic test_ramp();
        stim.delete();
        for (int i = 0; i < 2100; i++) stim.push_back(i % DEPTH);
        run_capture("ramp_rise", TRIG_RISE, 512, 1'b0, 0, 0, -1);
    endtask

    task automatic test_edges();
        stim.delete();
        for (int i = 0; i <= PRE; i++) stim.push_back(600);
        for (int i = 0; i < 1100; i++) stim.push_back(400);
        run_capture("fall_600_400", TRIG_FALL, 500, 1'b0, 0, 0, -1);
        stim.delete();
        for (int i = 0; i <= PRE; i++) stim.push_back(600);
        for (int i = 0; i < 40; i++) stim.push_back(400);
        run_capture("rise_600_400", TRIG_RISE, 500, 1'b0, 0, 1, -1);
    endtask

    task automatic test_force();
        stim.delete();
        for (int i = 0; i < PRE + 1100; i++) stim.push_back(100);
        run_capture("force_flat", TRIG_RISE, 512, 1'b1, 0, 1, -1);
    endtask

    task automatic test_abort();
        stim.delete();
        for (int i = 0; i < 2100; i++) stim.push_back(i % DEPTH);
        run_capture("abort_post", TRIG_RISE, 300, 1'b0, 0, 0, 400);
        run_capture("rearm_ramp", TRIG_RISE, 512, 1'b0, 0, 0, -1);
    endtask

    task automatic test_gaps();
        stim.delete();
        for (int i = 0; i < PRE + 1300; i++) stim.push_back($urandom_range(DEPTH-1, 0));
        run_capture("gap_1in3", logic'($urandom_range(1, 0)), $urandom_range(900, 100), 1'b0, 2, 2, -1);
    endtask

    task automatic test_long_pretrig();
        stim.delete();
        for (int i = 0; i < 1000; i++) stim.push_back(i % 500);
        stim.push_back(600);
        for (int i = 0; i < 1030; i++) stim.push_back($urandom_range(DEPTH-1, 0));
        run_capture("long_pretrig", TRIG_RISE, 512, 1'b0, 0, 0, -1);
    endtask

    task automatic test_reset_mid();
        trig_edge  = TRIG_RISE;
        trig_level = DATA_W'(100);
        trig_force = 1'b0;
        wren       = 1'b1;
        adc_valid  = 1'b0;
        step();
        for (int i = 0; i < 600; i++) begin
            adc_data  = DATA_W'(i + 1);
            adc_valid = 1'b1;
            step();
        end
        n_checks++;
        if (ram_we !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_capture_active: got we=%b busy=%b want 1 1", ram_we, busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({ram_we, ram_waddr, ram_wdata, busy, done, trig_addr} !== '0) begin
            n_fail++; $display("FAIL async_reset: got we=%b waddr=%0d wdata=%0d busy=%b done=%b taddr=%0d want all 0",
                               ram_we, ram_waddr, ram_wdata, busy, done, trig_addr);
        end
        adc_valid = 1'b0;
        wren      = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got busy=%b we=%b want 0 0", busy, ram_we);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        wren       = 1'b0;
        adc_data   = '0;
        adc_valid  = 1'b0;
        trig_level = '0;
        trig_edge  = TRIG_RISE;
        trig_force = 1'b0;
        test_reset();
        test_ramp();
        test_edges();
        test_force();
        test_abort();
        test_gaps();
        test_long_pretrig();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
